// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops words from a show-ahead FIFO and shifts each one out
// as a start / data (LSB first) / optional parity / stop frame.
module uart_tx_fifo_drain #(
   parameter int unsigned BAUD_DIV  = 868,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_ren,
   output logic                 tx,
   output logic                 busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR_BIT, STOP} state_t;

   localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [3:0]  LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP  = 4'(STOP_BITS - 1);
   localparam logic        HAS_PARITY = (PARITY != 0);

   state_t               state_reg, state_next;
   logic [15:0]          baud_cnt_reg, baud_cnt_next;
   logic [3:0]           bit_idx_reg, bit_idx_next;
   logic [DATA_BITS-1:0] word_reg, word_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 tx_reg, tx_next;
   logic                 ren_reg, ren_next;
   logic                 busy_reg, busy_next;
   logic                 bit_end;
   logic                 parity_bit;

   assign bit_end    = (baud_cnt_reg == BAUD_LAST);
   // Parity comes from the word captured at pop time; the FIFO head has moved on by then.
   assign parity_bit = (PARITY == 1) ? ~^word_reg : ^word_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         word_reg     <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         ren_reg      <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         word_reg     <= word_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
         ren_reg      <= ren_next;
         busy_reg     <= busy_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = bit_end ? 16'd0 : baud_cnt_reg + 16'd1;
      bit_idx_next  = bit_idx_reg;
      word_next     = word_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      ren_next      = 1'b0;
      busy_next     = busy_reg;

      case (state_reg)
         IDLE: begin
            baud_cnt_next = '0;
            bit_idx_next  = '0;
            tx_next       = 1'b1;
            busy_next     = 1'b0;
            if (en && !fifo_empty) begin
               word_next  = fifo_data;
               shift_next = fifo_data;
               ren_next   = 1'b1;
               busy_next  = 1'b1;
               tx_next    = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_next      = shift_reg[0];
               shift_next   = shift_reg >> 1;
               bit_idx_next = '0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx_reg == LAST_DATA) begin
                  bit_idx_next = '0;
                  if (HAS_PARITY) begin
                     tx_next    = parity_bit;
                     state_next = PAR_BIT;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end
               end else begin
                  bit_idx_next = bit_idx_reg + 4'd1;
                  tx_next      = shift_reg[0];
                  shift_next   = shift_reg >> 1;
               end
            end
         end
         PAR_BIT: begin
            if (bit_end) begin
               tx_next      = 1'b1;
               bit_idx_next = '0;
               state_next   = STOP;
            end
         end
         STOP: begin
            // bit_idx doubles as the stop-bit counter here.
            if (bit_end) begin
               if (bit_idx_reg == LAST_STOP) begin
                  bit_idx_next = '0;
                  busy_next    = 1'b0;
                  state_next   = IDLE;
               end else begin
                  bit_idx_next = bit_idx_reg + 4'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign tx       = tx_reg;
   assign fifo_ren = ren_reg;
   assign busy     = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances (plain, even parity, odd parity, two stop bits)
// each fed by a small FIFO model; a scoreboard of queued words checks every frame clock by clock.
module tb_uart_tx_fifo_drain;

   localparam int BAUD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] en = '0;
   logic [3:0] fifo_empty;
   logic [7:0] fifo_data [4];
   logic [3:0] ren;
   logic [3:0] tx;
   logic [3:0] busy;

   logic [7:0] mem [4][16];
   int         tail [4];
   int         frames_done [4];
   int         ren_gap [4];
   int         cycle = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic exp_bit(logic [7:0] w, int b, int par);
      if (b == 0) return 1'b0;
      if (b <= 8) return w[b-1];
      if (b == 9 && par != 0) return (par == 1) ? ~^w : ^w;
      return 1'b1;
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_mon
      localparam int PAR = (gi == 1) ? 2 : (gi == 2) ? 1 : 0;
      localparam int STB = (gi == 3) ? 2 : 1;
      localparam int NB  = 1 + 8 + ((PAR != 0) ? 1 : 0) + STB;

      logic [7:0] sb_q [$];
      int         head = 0;
      int         last_ren = -1;

      uart_tx_fifo_drain #(
         .BAUD_DIV (BAUD),
         .DATA_BITS(8),
         .PARITY   (PAR),
         .STOP_BITS(STB)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .en        (en[gi]),
         .fifo_empty(fifo_empty[gi]),
         .fifo_data (fifo_data[gi]),
         .fifo_ren  (ren[gi]),
         .tx        (tx[gi]),
         .busy      (busy[gi])
      );

      assign fifo_empty[gi] = (head == tail[gi]);
      assign fifo_data[gi]  = mem[gi][head[3:0]];
      always @(posedge clk) if (ren[gi] === 1'b1) head <= head + 1;

      initial begin
         logic [7:0] w;
         logic       ab;
         forever begin
            @(negedge clk);
            if (!rst && ren[gi] === 1'b1) begin
               if (last_ren >= 0) ren_gap[gi] = cycle - last_ren;
               last_ren = cycle;
               check_val($sformatf("i%0d_sb_nonempty", gi), (sb_q.size() > 0), 1);
               w  = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
               ab = 1'b0;
               for (int b = 0; b < NB && !ab; b++) begin
                  for (int c = 0; c < BAUD && !ab; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (rst) ab = 1'b1;
                     else begin
                        check_val($sformatf("i%0d_tx_b%0d_c%0d", gi, b, c), tx[gi], exp_bit(w, b, PAR));
                        check_val($sformatf("i%0d_busy_b%0d", gi, b), busy[gi], 1);
                        check_val($sformatf("i%0d_ren_b%0d_c%0d", gi, b, c), ren[gi], (b == 0 && c == 0));
                     end
                  end
               end
               if (!ab) begin
                  @(negedge clk);
                  if (!rst) begin
                     check_val($sformatf("i%0d_idle_tx", gi), tx[gi], 1);
                     check_val($sformatf("i%0d_idle_busy", gi), busy[gi], 0);
                     frames_done[gi]++;
                     $display("frame inst %0d word %02h bits %0d done at cycle %0d", gi, w, NB, cycle);
                  end
               end else begin
                  $display("frame inst %0d word %02h abandoned by reset", gi, w);
               end
            end
         end
      end
   end

   task automatic push_word(int i, logic [7:0] w);
      mem[i][tail[i] % 16] = w;
      tail[i]++;
      case (i)
         0: g_mon[0].sb_q.push_back(w);
         1: g_mon[1].sb_q.push_back(w);
         2: g_mon[2].sb_q.push_back(w);
         default: g_mon[3].sb_q.push_back(w);
      endcase
   endtask

   task automatic wait_frames(int i, int n, int budget);
      int k = 0;
      while (frames_done[i] < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_val($sformatf("i%0d_frames_%0d", i, n), frames_done[i], n);
   endtask

   initial begin
      int bad;
      int k;
      for (int i = 0; i < 4; i++) begin
         tail[i] = 0;
         frames_done[i] = 0;
         ren_gap[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("rst_tx_%0d", i), tx[i], 1);
         check_val($sformatf("rst_busy_%0d", i), busy[i], 0);
         check_val($sformatf("rst_ren_%0d", i), ren[i], 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Single word, no parity
      en[0] = 1'b1;
      push_word(0, 8'hA5);
      wait_frames(0, 1, 100);

      // Even and odd parity run side by side
      en[1] = 1'b1;
      en[2] = 1'b1;
      push_word(1, 8'h07);
      push_word(2, 8'h07);
      wait_frames(1, 1, 100);
      wait_frames(2, 1, 100);

      // Back-to-back words
      push_word(0, 8'h55);
      push_word(0, 8'h0F);
      wait_frames(0, 3, 200);
      check_val("i0_ren_gap", ren_gap[0], 41);

      // Enable held low with data waiting
      en[0] = 1'b0;
      push_word(0, 8'h3C);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ren[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
      end
      check_val("en_low_hold", bad, 0);
      en[0] = 1'b1;
      @(negedge clk);
      check_val("en_rise_capture", ren[0], 1);
      wait_frames(0, 4, 100);

      // Reset in the middle of data bit 3
      push_word(0, 8'h96);
      push_word(0, 8'h81);
      k = 0;
      while (ren[0] !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check_val("rst_test_ren_seen", ren[0], 1);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("midrst_tx", tx[0], 1);
      check_val("midrst_busy", busy[0], 0);
      check_val("midrst_ren", ren[0], 0);
      @(negedge clk);
      rst = 1'b0;
      wait_frames(0, 5, 100);

      // Two stop bits, FIFO empty afterwards
      en[3] = 1'b1;
      push_word(3, 8'hC3);
      wait_frames(3, 1, 100);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ren[3] !== 1'b0 || tx[3] !== 1'b1 || busy[3] !== 1'b0) bad++;
      end
      check_val("stop2_quiet", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
